// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential/branch/call/return/exception next-PC
// selection with a circular return-address stack and sticky stack error flags.
module pc_unit #(
  parameter int unsigned       WIDTH     = 16,
  parameter int unsigned       STEP      = 2,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter logic [WIDTH-1:0]  EXC_VEC   = 16'h0010,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             hazrd,
  input  logic                             exc,
  input  logic                             branch,
  input  logic                             call,
  input  logic                             ret,
  input  logic [WIDTH-1:0]                 target,
  input  logic                             clr_err,
  output logic [WIDTH-1:0]                 pc_out,
  output logic [WIDTH-1:0]                 epc,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_ovf,
  output logic                             ras_unf
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top, top_nxt, wr_idx;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] pc_nxt, epc_nxt, seq_pc, wr_data;
  logic             wr_en, ovf_set, unf_set, empty, full;

  assign empty = (ras_count == '0);
  assign full  = (ras_count == CW'(RAS_DEPTH));

  always_comb begin
    seq_pc  = pc_out + WIDTH'(STEP);
    pc_nxt  = seq_pc;
    epc_nxt = epc;
    top_nxt = top;
    cnt_nxt = ras_count;
    wr_en   = 1'b0;
    wr_idx  = top + PW'(1);
    wr_data = seq_pc;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (exc) begin
      pc_nxt  = EXC_VEC;
      epc_nxt = pc_out;
    end else if (hazrd) begin
      pc_nxt = pc_out;
    end else if (call && ret) begin
      // Tail call replaces the top entry in place; on an empty stack it degrades to a push.
      wr_en  = 1'b1;
      pc_nxt = target;
      if (empty) begin
        top_nxt = top + PW'(1);
        cnt_nxt = CW'(1);
        unf_set = 1'b1;
      end else begin
        wr_idx = top;
      end
    end else if (ret) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        pc_nxt  = ras_mem[top];
        top_nxt = top - PW'(1);
        cnt_nxt = ras_count - CW'(1);
      end
    end else if (call) begin
      // When full, top+1 lands on the oldest entry, so the push overwrites it.
      wr_en   = 1'b1;
      pc_nxt  = target;
      top_nxt = top + PW'(1);
      if (full) ovf_set = 1'b1;
      else      cnt_nxt = ras_count + CW'(1);
    end else if (branch) begin
      pc_nxt = target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out    <= RESET_VEC;
      epc       <= '0;
      top       <= '0;
      ras_count <= '0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else begin
      pc_out    <= pc_nxt;
      epc       <= epc_nxt;
      top       <= top_nxt;
      ras_count <= cnt_nxt;
      ras_ovf   <= (ras_ovf & ~clr_err) | ovf_set;
      ras_unf   <= (ras_unf & ~clr_err) | unf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) ras_mem[wr_idx] <= wr_data;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter unit for the pipelined CPU fetch stage. It replaces the fixed 16-bit PC register, which had only a hazard hold. The unit generates the next fetch address from these sources: sequential increment, branch target, call/return through an internal return-address stack (RAS), and exception vectoring. It sits between the hazard unit and branch resolution on the input side and the instruction memory address port on the output side.

Parameters:
WIDTH, 16, address width in bits; all PC arithmetic is modulo 2^WIDTH
STEP, 2, sequential increment added to the PC each unstalled cycle
RESET_VEC, 0, pc_out value during and after reset
EXC_VEC, 16'h0010, exception handler address (truncated/zero-extended to WIDTH)
RAS_DEPTH, 4, return-address stack entries (>=2, power of two)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
hazrd  in  1  stall: hold PC and RAS
exc  in  1  exception request
branch  in  1  taken branch/jump to target
call  in  1  call: push return address, jump to target
ret  in  1  return: pop RAS, jump to popped address
target  in  WIDTH  branch/call destination
clr_err  in  1  clears sticky ras_ovf/ras_unf
pc_out  out  WIDTH  current fetch address (registered)
epc  out  WIDTH  PC captured at last exception (registered)
ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
ras_ovf  out  1  sticky: push while full occurred
ras_unf  out  1  sticky: pop while empty occurred

Behaviour:
- Reset (async, rst=1): pc_out=RESET_VEC, epc=0, ras_count=0, ras_ovf=0, ras_unf=0; RAS contents don't-care. Release takes effect at the next rising edge; first update computes from RESET_VEC.
- Per rising edge, priority, highest first:
  1. exc: pc_out<=EXC_VEC, epc<=pc_out. RAS untouched. Applies even with hazrd=1.
  2. hazrd: pc_out, RAS, and ras_count hold. branch/call/ret are ignored; upstream keeps them asserted until the stall clears.
  3. ret & call (tail call): top entry<=pc_out+STEP, pc_out<=target, count unchanged. If empty: push only (count=1), ras_unf<=1.
  4. ret: if count>0, pc_out<=top entry, count-1. If empty: pc_out<=pc_out+STEP, ras_unf<=1.
  5. call: push pc_out+STEP, pc_out<=target. If full: overwrite oldest entry (circular), count stays RAS_DEPTH, ras_ovf<=1.
  6. branch: pc_out<=target.
  7. default: pc_out<=pc_out+STEP.
- branch together with call or ret: call/ret wins; branch ignored.
- Arithmetic: the WIDTH-bit sum drops its carry, so the maximum address + STEP wraps to the low addresses (e.g. 16'hFFFE+2 = 0).
- RAS: circular buffer, top pointer plus count. Latency 1 cycle (pop value visible on pc_out the cycle after ret). Return addresses survive exceptions.
- Sticky flags: clear only on rst or clr_err. If clr_err and a new error occur on the same edge, the flag sets.
- Reset mid-operation: immediate return to reset state; RAS is logically emptied.

Test Plan:
- Reset/increment: rst=1 for 5ns, release; 3 free edges -> pc_out 0,2,4,6; hold rst mid-run -> pc_out=0 asynchronously, before the next edge.
- Stall and wrap: preset PC 16'hFFFC; hazrd=1 for 1 cycle -> holds FFFC; then FFFE, 0000.
- Branch vs call priority: pc=0x0020, branch=1 + call=1, target=0x1234 -> pc=0x1234, ras_count=1; ret -> pc=0x0022, ras_count=0.
- RAS overflow/underflow: 5 nested calls (DEPTH 4) -> ras_ovf=1, count=4; 4 rets return the 4 newest return addresses in LIFO order; 5th ret -> pc=prev+2, ras_unf=1; clr_err -> both flags 0.
- Exception during stall: pc=0x0040, hazrd=1, exc=1 -> pc=0x0010, epc=0x0040; RAS count unchanged.
- Tail call: stack [0x0102], pc=0x0200, call=ret=1, target=0x0300 -> pc=0x0300, top=0x0202, count=1.
